// File: rtl/clk_div_bank_if.sv
// Configuration write channel for clk_div_bank: a valid/ready handshake carrying
// a channel index and the new divisor for that channel.
interface clk_div_bank_if #(
    parameter int CH_W  = 2,
    parameter int DIV_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;

    modport master (output cfg_valid, output cfg_ch, output cfg_div, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_ch, input cfg_div, output cfg_ready);
endinterface

// File: rtl/clk_div_bank.sv
// Multi-channel runtime-programmable clock-enable divider. Each channel emits a
// low-first square wave and a last-cycle tick; new divisors apply at period wrap.
module clk_div_bank #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 4,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    clk_div_bank_if.slave     cfg,
    input  logic              sync,
    output logic [NUM_CH-1:0] div_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);
    localparam logic [CH_W:0]    NUM_CH_L  = (CH_W+1)'(NUM_CH);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(DEFAULT_DIV);

    // ceil(n/2) without widening, so n = 2^DIV_W-1 cannot overflow
    function automatic logic [DIV_W-1:0] ceil_half(input logic [DIV_W-1:0] n);
        return (n >> 1) + DIV_W'(n[0]);
    endfunction

    function automatic logic last_cycle(input logic [DIV_W-1:0] c, input logic [DIV_W-1:0] n);
        return (n <= DIV_ONE) || (c == n - DIV_ONE);
    endfunction

    logic [DIV_W-1:0]  cnt   [NUM_CH];
    logic [DIV_W-1:0]  n_act [NUM_CH];
    logic [DIV_W-1:0]  p_div [NUM_CH];
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] wr;
    logic [NUM_CH-1:0] wrap;
    logic              in_range;
    logic              sel_pend;
    logic              accept;

    always_comb begin
        in_range = {1'b0, cfg.cfg_ch} < NUM_CH_L;
        sel_pend = 1'b0;
        wr       = '0;
        wrap     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg.cfg_ch == CH_W'(i)) sel_pend = pend[i];
        end
        // out-of-range writes are always "accepted" and silently dropped
        accept        = cfg.cfg_valid && in_range && !sel_pend;
        cfg.cfg_ready = !(in_range && sel_pend);
        for (int i = 0; i < NUM_CH; i++) begin
            wr[i]   = accept && (cfg.cfg_ch == CH_W'(i));
            wrap[i] = last_cycle(cnt[i], n_act[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]   <= '0;
                n_act[i] <= DIV_RESET;
                pend[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (sync) begin
                    cnt[i]  <= '0;
                    pend[i] <= 1'b0;
                    if (wr[i])        n_act[i] <= cfg.cfg_div;
                    else if (pend[i]) n_act[i] <= p_div[i];
                end else if (pend[i] && wrap[i]) begin
                    cnt[i]   <= '0;
                    n_act[i] <= p_div[i];
                    pend[i]  <= 1'b0;
                end else begin
                    cnt[i] <= wrap[i] ? '0 : cnt[i] + DIV_ONE;
                    if (wr[i]) pend[i] <= 1'b1;
                end
            end
        end
    end

    // Pending divisor is only meaningful while pend is set, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr[i]) p_div[i] <= cfg.cfg_div;
        end
    end

    always_comb begin
        div_out = '0;
        tick    = '0;
        pending = pend;
        for (int i = 0; i < NUM_CH; i++) begin
            if (n_act[i] == DIV_ONE) begin
                div_out[i] = 1'b1;
                tick[i]    = 1'b1;
            end else if (n_act[i] > DIV_ONE) begin
                div_out[i] = cnt[i] >= ceil_half(n_act[i]);
                tick[i]    = cnt[i] == n_act[i] - DIV_ONE;
            end
        end
    end
endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: a per-cycle reference model feeds a
// scoreboard queue, and each scenario task adds its own directed checks.
module tb_clk_div_bank;
    localparam int NUM  = 4;
    localparam int DW   = 8;
    localparam int DEF  = 4;
    localparam int CHW  = 3;

    logic clk = 1'b0;
    logic rst;
    logic sync;
    logic [NUM-1:0] div_out, tick, pending;

    clk_div_bank_if #(.CH_W(CHW), .DIV_W(DW)) cfg ();

    clk_div_bank #(.NUM_CH(NUM), .DIV_W(DW), .DEFAULT_DIV(DEF), .CH_W(CHW)) dut (
        .clk(clk), .rst(rst), .cfg(cfg.slave), .sync(sync),
        .div_out(div_out), .tick(tick), .pending(pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct { logic [NUM-1:0] d; logic [NUM-1:0] t; logic [NUM-1:0] p; } exp_t;
    exp_t sbq[$];

    int m_cnt [NUM];
    int m_n   [NUM];
    int m_p   [NUM];
    bit m_pend[NUM];

    // Reference model: advances on every edge and queues the outputs it expects next.
    always @(posedge clk) begin
        int acc, c, last;
        exp_t e;
        if (rst) begin
            for (int i = 0; i < NUM; i++) begin
                m_cnt[i] = 0; m_n[i] = DEF; m_p[i] = 0; m_pend[i] = 0;
            end
        end else begin
            c   = int'(cfg.cfg_ch);
            acc = -1;
            if (cfg.cfg_valid && c < NUM) if (!m_pend[c]) acc = c;
            for (int i = 0; i < NUM; i++) begin
                last = (m_n[i] <= 1) || (m_cnt[i] == m_n[i] - 1);
                if (sync) begin
                    m_cnt[i] = 0;
                    if (i == acc) m_n[i] = int'(cfg.cfg_div);
                    else if (m_pend[i]) m_n[i] = m_p[i];
                    m_pend[i] = 0;
                end else begin
                    if (m_pend[i] && last) begin
                        m_n[i] = m_p[i]; m_cnt[i] = 0; m_pend[i] = 0;
                    end else begin
                        m_cnt[i] = last ? 0 : m_cnt[i] + 1;
                    end
                    if (i == acc) begin m_p[i] = int'(cfg.cfg_div); m_pend[i] = 1; end
                end
            end
        end
        for (int i = 0; i < NUM; i++) begin
            e.d[i] = (m_n[i] == 1) || (m_n[i] >= 2 && m_cnt[i] >= m_n[i] - m_n[i] / 2);
            e.t[i] = (m_n[i] >= 1) && (m_cnt[i] == m_n[i] - 1);
            e.p[i] = m_pend[i];
        end
        sbq.push_back(e);
    end

    // Advance one clock and compare the DUT against the oldest queued expectation.
    task automatic sb_advance();
        exp_t e;
        @(posedge clk);
        #1;
        checks++;
        if (sbq.size() == 0) begin
            failures++;
            $display("FAIL sb_empty t=%0t: no expectation queued", $time);
        end else begin
            e = sbq.pop_front();
            if (div_out !== e.d || tick !== e.t || pending !== e.p) begin
                failures++;
                $display("FAIL scoreboard t=%0t got div=%b tick=%b pend=%b want div=%b tick=%b pend=%b",
                         $time, div_out, tick, pending, e.d, e.t, e.p);
            end
        end
    endtask

    task automatic test_reset();
        logic [NUM-1:0] wd, wt;
        rst = 1'b1; sync = 1'b0;
        cfg.cfg_valid = 1'b0; cfg.cfg_ch = '0; cfg.cfg_div = '0;
        sb_advance();
        sb_advance();
        rst = 1'b0;
        checks++;
        if (div_out !== 4'h0 || tick !== 4'h0 || pending !== 4'h0 || cfg.cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state div=%b tick=%b pend=%b rdy=%b want 0000 0000 0000 1",
                     div_out, tick, pending, cfg.cfg_ready);
        end
        for (int k = 0; k < 8; k++) begin
            wd = (k % 4 >= 2) ? 4'hF : 4'h0;
            wt = (k % 4 == 3) ? 4'hF : 4'h0;
            checks++;
            if (div_out !== wd || tick !== wt) begin
                failures++;
                $display("FAIL reset_pattern k=%0d div=%b tick=%b want %b %b", k, div_out, tick, wd, wt);
            end
            sb_advance();
        end
    endtask

    task automatic test_write_n5();
        int pc;
        cfg.cfg_valid = 1'b1; cfg.cfg_ch = 3'd1; cfg.cfg_div = 8'd5;
        checks++;
        if (cfg.cfg_ready !== 1'b1) begin
            failures++; $display("FAIL n5_ready got %b want 1", cfg.cfg_ready);
        end
        sb_advance();
        cfg.cfg_valid = 1'b0;
        pc = 0;
        while (pending[1] === 1'b1 && pc < 20) begin pc++; sb_advance(); end
        checks++;
        if (pc != 3) begin failures++; $display("FAIL n5_pending_cycles got %0d want 3", pc); end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (div_out[1] !== (k % 5 >= 3) || tick[1] !== (k % 5 == 4)) begin
                failures++;
                $display("FAIL n5_wave k=%0d div=%b tick=%b want %b %b", k, div_out[1], tick[1], k % 5 >= 3, k % 5 == 4);
            end
            sb_advance();
        end
    endtask

    task automatic test_back_to_back();
        int stall, w;
        cfg.cfg_valid = 1'b1; cfg.cfg_ch = 3'd2; cfg.cfg_div = 8'd7;
        sb_advance();
        cfg.cfg_div = 8'd3;
        stall = 0;
        while (cfg.cfg_ready !== 1'b1 && stall < 20) begin
            checks++;
            if (pending[2] !== 1'b1) begin failures++; $display("FAIL b2b_stall_pend got %b want 1", pending[2]); end
            stall++;
            sb_advance();
        end
        checks++;
        if (stall < 1 || stall > 4 || pending[2] !== 1'b0) begin
            failures++; $display("FAIL b2b_stall stall=%0d pend=%b want 1..4 and 0", stall, pending[2]);
        end
        sb_advance();
        cfg.cfg_valid = 1'b0;
        checks++;
        if (pending[2] !== 1'b1) begin failures++; $display("FAIL b2b_second_accept pend=%b want 1", pending[2]); end
        w = 0;
        while (pending[2] === 1'b1 && w < 10) begin w++; sb_advance(); end
        checks++;
        if (w < 1 || w > 7) begin failures++; $display("FAIL b2b_apply_wait got %0d want 1..7", w); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (tick[2] !== (k % 3 == 2)) begin
                failures++; $display("FAIL b2b_n3_tick k=%0d got %b want %b", k, tick[2], k % 3 == 2);
            end
            sb_advance();
        end
    endtask

    task automatic test_n0_n1();
        int w;
        cfg.cfg_valid = 1'b1; cfg.cfg_ch = 3'd0; cfg.cfg_div = 8'd0;
        sb_advance();
        cfg.cfg_valid = 1'b0;
        w = 0;
        while (pending[0] === 1'b1 && w < 10) begin w++; sb_advance(); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (div_out[0] !== 1'b0 || tick[0] !== 1'b0) begin
                failures++; $display("FAIL n0_quiet k=%0d div=%b tick=%b want 0 0", k, div_out[0], tick[0]);
            end
            sb_advance();
        end
        cfg.cfg_valid = 1'b1; cfg.cfg_div = 8'd1;
        sb_advance();
        cfg.cfg_valid = 1'b0;
        checks++;
        if (pending[0] !== 1'b1) begin failures++; $display("FAIL n1_pend_pulse got %b want 1", pending[0]); end
        sb_advance();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (pending[0] !== 1'b0 || div_out[0] !== 1'b1 || tick[0] !== 1'b1) begin
                failures++;
                $display("FAIL n1_const k=%0d pend=%b div=%b tick=%b want 0 1 1", k, pending[0], div_out[0], tick[0]);
            end
            sb_advance();
        end
    endtask

    task automatic test_sync();
        int w;
        for (int ch = 1; ch <= 2; ch++) begin
            cfg.cfg_valid = 1'b1; cfg.cfg_ch = CHW'(ch); cfg.cfg_div = 8'd6;
            sb_advance();
            cfg.cfg_valid = 1'b0;
            w = 0;
            while (pending[ch] === 1'b1 && w < 10) begin w++; sb_advance(); end
            sb_advance();
            sb_advance();
        end
        sync = 1'b1;
        cfg.cfg_valid = 1'b1; cfg.cfg_ch = 3'd3; cfg.cfg_div = 8'd8;
        sb_advance();
        sync = 1'b0; cfg.cfg_valid = 1'b0;
        checks++;
        if (pending !== 4'h0 || div_out !== 4'b0001 || tick !== 4'b0001) begin
            failures++;
            $display("FAIL sync_edge pend=%b div=%b tick=%b want 0000 0001 0001", pending, div_out, tick);
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (div_out[1] !== div_out[2] || tick[1] !== tick[2] ||
                tick[1] !== (k % 6 == 5) || tick[3] !== (k % 8 == 7)) begin
                failures++;
                $display("FAIL sync_lock k=%0d div=%b tick=%b", k, div_out, tick);
            end
            sb_advance();
        end
        sync = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sb_advance();
            checks++;
            if (div_out[3:1] !== 3'b000 || tick[3:1] !== 3'b000 || tick[0] !== 1'b1) begin
                failures++; $display("FAIL sync_hold k=%0d div=%b tick=%b want 000x 0001", k, div_out, tick);
            end
        end
        sync = 1'b0;
    endtask

    task automatic test_max_reset();
        int w, lo, hi, nt, tk;
        cfg.cfg_valid = 1'b1; cfg.cfg_ch = 3'd3; cfg.cfg_div = 8'd255;
        sb_advance();
        cfg.cfg_valid = 1'b0;
        w = 0;
        while (pending[3] === 1'b1 && w < 20) begin w++; sb_advance(); end
        lo = 0; hi = 0; nt = 0; tk = -1;
        for (int k = 0; k < 255; k++) begin
            if (div_out[3] === 1'b1) hi++; else lo++;
            if (tick[3] === 1'b1) begin nt++; tk = k; end
            sb_advance();
        end
        checks++;
        if (lo != 128 || hi != 127 || nt != 1 || tk != 254) begin
            failures++; $display("FAIL n255_period lo=%0d hi=%0d ticks=%0d at=%0d want 128 127 1 254", lo, hi, nt, tk);
        end
        cfg.cfg_valid = 1'b1; cfg.cfg_ch = 3'd5; cfg.cfg_div = 8'd9;
        checks++;
        if (cfg.cfg_ready !== 1'b1) begin failures++; $display("FAIL oor_ready got %b want 1", cfg.cfg_ready); end
        sb_advance();
        cfg.cfg_valid = 1'b0;
        checks++;
        if (pending !== 4'h0) begin failures++; $display("FAIL oor_dropped pend=%b want 0000", pending); end
        repeat (10) sb_advance();
        cfg.cfg_valid = 1'b1; cfg.cfg_ch = 3'd2; cfg.cfg_div = 8'd9;
        sb_advance();
        cfg.cfg_valid = 1'b0;
        checks++;
        if (pending[2] !== 1'b1) begin failures++; $display("FAIL prereset_pend got %b want 1", pending[2]); end
        rst = 1'b1;
        sb_advance();
        rst = 1'b0;
        checks++;
        if (pending !== 4'h0 || div_out !== 4'h0 || tick !== 4'h0 || cfg.cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset pend=%b div=%b tick=%b rdy=%b want 0000 0000 0000 1",
                     pending, div_out, tick, cfg.cfg_ready);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (div_out !== ((k % 4 >= 2) ? 4'hF : 4'h0) || tick !== ((k % 4 == 3) ? 4'hF : 4'h0)) begin
                failures++; $display("FAIL postreset_default k=%0d div=%b tick=%b", k, div_out, tick);
            end
            sb_advance();
        end
    endtask

    initial begin
        test_reset();
        test_write_n5();
        test_back_to_back();
        test_n0_n1();
        test_sync();
        test_max_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
